right_shifter_16bit: RTL and testbench
======================================

RIGHT_SHIFTER_16BIT -- requirements
Module: right_shifter_16bit

Interface
REQ-001 Parameter DATA_W, default 16, operand and result width; only 16 is supported.
REQ-002 Parameter SHAMT_W, default 4, shift-amount width, equal to log2(DATA_W).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  high when A and mag carry a new operation this cycle.
REQ-006 A  input  16  operand to be shifted.
REQ-007 mag  input  4  shift amount, unsigned, 0..15.
REQ-008 Q  output  16  registered shift result.
REQ-009 out_valid  output  1  high for one cycle when Q holds a new result.

Function
REQ-010 The block SHALL compute a logical right shift, Q = A >> mag, with zero fill from the MSB side; the sign bit is not replicated.
REQ-011 mag = 0 SHALL pass A through unchanged.
REQ-012 mag = 15 SHALL give Q = {15'b0, A[15]}.
REQ-013 Bits shifted past bit 0 SHALL be discarded; there is no carry, sticky or rotate output.
REQ-014 The shift SHALL be a 4-stage logarithmic barrel structure: stage k shifts by 2^k when mag[k] = 1, for k = 0..3, in order k = 0 first.
REQ-015 Latency SHALL be exactly 1 clock: A and mag sampled with in_valid = 1 at edge N appear on Q with out_valid = 1 after edge N.
REQ-016 On any edge where in_valid = 0 and rst_n = 1, Q SHALL hold its previous value and out_valid SHALL be 0.
REQ-017 Back-to-back in_valid cycles SHALL each produce a result on consecutive cycles; throughput is one result per clock.
REQ-018 There is no backpressure; the consumer SHALL capture Q in the cycle out_valid is high.
REQ-019 X/undefined A or mag with in_valid = 0 SHALL NOT affect Q.

Reset
REQ-020 When rst_n = 0 at a rising clk edge, Q SHALL become 16'h0000 and out_valid SHALL become 0.
REQ-021 Reset SHALL take priority over in_valid; an operation presented in the same cycle as reset is dropped.
REQ-022 An operation accepted at the edge before reset asserts SHALL NOT appear after reset; Q reads 0.
REQ-023 The first valid operation after rst_n deasserts SHALL follow the normal 1-cycle latency.

Structure
REQ-024 DATA_W and SHAMT_W defaults SHALL live in the shared project package as constants, together with a 16-bit data typedef.
REQ-025 One sub-module, right_shift_stage, SHALL be used.
REQ-026 right_shift_stage is a combinational stage with ports din[15:0], en, dout[15:0] and a SHIFT parameter; dout = en ? din >> SHIFT : din.
REQ-027 right_shift_stage SHALL be instantiated four times, with SHIFT = 1, 2, 4 and 8.
REQ-028 The output register and out_valid register SHALL be the only state in the top level.

Verification
REQ-029 Walking shift: A = 16'h8000, mag = 0..15 on consecutive cycles, in_valid = 1 -> Q one cycle later is 8000, 4000, 2000, 1000, 0800, ... 0002, 0001, with out_valid high each cycle.
REQ-030 Full drop: A = 16'h1111, mag = 4'hF -> Q = 16'h0000. A = 16'hFFFF, mag = 4'hF -> Q = 16'h0001.
REQ-031 Pattern: A = 16'h1010, mag = 1 -> Q = 16'h0808. A = 16'hA5A5, mag = 4 -> Q = 16'h0A5A. A = 16'h8001, mag = 0 -> Q = 16'h8001.
REQ-032 Hold: after Q = 16'h0808, drive in_valid = 0 with A = 16'hFFFF, mag = 0 for 3 cycles -> Q stays 16'h0808 and out_valid stays 0.
REQ-033 Reset mid-stream: rst_n = 0 in the same cycle as in_valid = 1, A = 16'hFFFF, mag = 0 -> next cycle Q = 16'h0000 and out_valid = 0. After release, A = 16'h0F00, mag = 8 -> Q = 16'h000F after 1 cycle.
REQ-034 Exhaustive check: every mag with random A, compared each cycle against the A >> mag model delayed by one cycle.

Source files
------------

// File: rtl/right_shifter_16bit_pkg.sv
// Shared constants and types for the 16-bit logical right shifter.
//   DATA_W_DEF  : operand/result width (only 16 is supported)
//   SHAMT_W_DEF : shift-amount width, log2(DATA_W_DEF)
//   data_t      : 16-bit data word
package right_shifter_16bit_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int SHAMT_W_DEF = 4;

  typedef logic [DATA_W_DEF-1:0] data_t;

endpackage : right_shifter_16bit_pkg

// File: rtl/right_shift_stage.sv
// One combinational stage of a logarithmic barrel right shifter.
// When en is high the word is shifted right by SHIFT with zero fill,
// otherwise it passes through untouched.
//   din  : input word
//   en   : apply this stage's shift
//   dout : stage result
module right_shift_stage
  import right_shifter_16bit_pkg::*;
#(
  parameter int SHIFT = 1
) (
  input  data_t din,
  input  logic  en,
  output data_t dout
);

  // Logical shift: vacated MSBs fill with zero, LSBs fall off the end.
  assign dout = en ? (din >> SHIFT) : din;

endmodule : right_shift_stage

// File: rtl/right_shifter_16bit.sv
// Registered 16-bit logical right shifter, Q = A >> mag, one-cycle latency,
// one result per clock, no backpressure.
//   clk       : clock, all state on rising edge
//   rst_n     : synchronous active-low reset (clears Q and out_valid)
//   in_valid  : A/mag carry an operation this cycle
//   A         : operand
//   mag       : shift amount 0..15
//   Q         : registered result, held while no new operation arrives
//   out_valid : one-cycle pulse marking a new result on Q
module right_shifter_16bit
  import right_shifter_16bit_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  A,
  input  logic [SHAMT_W-1:0] mag,
  output logic [DATA_W-1:0]  Q,
  output logic               out_valid
);

  // stage_data[k] is the word entering stage k; stage_data[SHAMT_W] is the result.
  data_t stage_data [0:SHAMT_W];

  assign stage_data[0] = A;

  // Stage k shifts by 2^k under control of mag[k], smallest shift first.
  for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
    right_shift_stage #(
      .SHIFT (1 << gi)
    ) u_stage (
      .din  (stage_data[gi]),
      .en   (mag[gi]),
      .dout (stage_data[gi+1])
    );
  end

  data_t q_d, q_q;
  logic  out_valid_d, out_valid_q;

  // Q only loads on a valid operation, so garbage on A/mag while idle
  // never reaches the register.
  always_comb begin
    q_d         = q_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      q_d         = stage_data[SHAMT_W];
      out_valid_d = 1'b1;
    end
  end

  // Reset wins over any operation presented in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      q_q         <= q_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign Q         = q_q;
  assign out_valid = out_valid_q;

endmodule : right_shifter_16bit

// File: tb/tb_right_shifter_16bit.sv
// Self-checking bench for right_shifter_16bit: directed cases plus random
// operands checked against an arithmetic (divide by a power of two) model.
module tb_right_shifter_16bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] A;
  logic [3:0]  mag;
  logic [15:0] Q;
  logic        out_valid;

  int total = 0;
  int bad   = 0;

  right_shifter_16bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .mag       (mag),
    .Q         (Q),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Reference: logical right shift is unsigned division by 2^m.
  function automatic logic [15:0] ref_shift(input logic [15:0] a, input int m);
    int unsigned v;
    v = int'(a) / (32'd1 << m);
    return v[15:0];
  endfunction

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample outputs away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [15:0] a, input logic [3:0] m);
    in_valid = 1'b1;
    A        = a;
    mag      = m;
    step();
  endtask

  task automatic show(input string tag);
    $display("%s: in_valid=%b A=%h mag=%0d -> Q=%h out_valid=%b", tag, in_valid, A, mag, Q, out_valid);
  endtask

  initial begin
    logic [15:0] exp_q;
    logic        exp_v;
    logic [15:0] ra;
    logic [3:0]  rm;
    logic        rv;

    // Reset with an operation presented: reset must win.
    rst_n = 1'b0; in_valid = 1'b1; A = 16'hFFFF; mag = 4'd0;
    step(); step();
    show("reset");
    chk16("reset_q", Q, 16'h0000);
    chk1 ("reset_v", out_valid, 1'b0);

    rst_n = 1'b1; in_valid = 1'b0;
    step();
    show("idle");
    chk16("idle_q", Q, 16'h0000);
    chk1 ("idle_v", out_valid, 1'b0);

    // Walking shift of a single MSB, back-to-back.
    for (int m = 0; m < 16; m++) begin
      op(16'h8000, 4'(m));
      show("walk");
      chk16($sformatf("walk_q_m%0d", m), Q, 16'(32'h8000 >> m));
      chk1 ($sformatf("walk_v_m%0d", m), out_valid, 1'b1);
    end

    // Full drop.
    op(16'h1111, 4'hF); show("drop"); chk16("drop_1111", Q, 16'h0000);
    op(16'hFFFF, 4'hF); show("drop"); chk16("drop_ffff", Q, 16'h0001);

    // Patterns.
    op(16'hA5A5, 4'd4); show("pat"); chk16("pat_a5a5", Q, 16'h0A5A);
    op(16'h8001, 4'd0); show("pat"); chk16("pat_8001", Q, 16'h8001);
    op(16'h1010, 4'd1); show("pat"); chk16("pat_1010", Q, 16'h0808);

    // Hold while idle, including undefined inputs.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b0; A = 16'hFFFF; mag = 4'd0;
      if (i == 2) begin A = 'x; mag = 'x; end
      step();
      show("hold");
      chk16($sformatf("hold_q_%0d", i), Q, 16'h0808);
      chk1 ($sformatf("hold_v_%0d", i), out_valid, 1'b0);
    end

    // Operation accepted just before reset must not survive it.
    rst_n = 1'b1;
    op(16'hFFFF, 4'd0); show("pre_rst"); chk16("pre_rst_q", Q, 16'hFFFF);
    rst_n = 1'b0;
    op(16'hFFFF, 4'd0); show("mid_rst");
    chk16("mid_rst_q", Q, 16'h0000);
    chk1 ("mid_rst_v", out_valid, 1'b0);
    rst_n = 1'b1;
    op(16'h0F00, 4'd8); show("post_rst");
    chk16("post_rst_q", Q, 16'h000F);
    chk1 ("post_rst_v", out_valid, 1'b1);

    // Random sweep: every mag several times, occasional idle cycles.
    exp_q = 16'h000F;
    for (int r = 0; r < 6; r++) begin
      for (int m = 0; m < 16; m++) begin
        ra = 16'($urandom);
        rm = 4'(m);
        rv = ($urandom_range(0, 4) != 0);
        in_valid = rv; A = ra; mag = rm;
        if (rv) begin
          exp_q = ref_shift(ra, m);
          exp_v = 1'b1;
        end else begin
          exp_v = 1'b0;
        end
        step();
        show("rand");
        chk16($sformatf("rand_q_r%0d_m%0d", r, m), Q, exp_q);
        chk1 ($sformatf("rand_v_r%0d_m%0d", r, m), out_valid, exp_v);
      end
    end

    in_valid = 1'b0;
    step();
    chk1("final_v", out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_right_shifter_16bit
